// File: rtl/stream2lite_rx_interface.sv
// AXI-Stream slave that captures one packet of up to four words into holding
// registers for the AXI-Lite register file, with done/overflow status.
module stream2lite_rx_interface #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic                              S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    input  logic                              arm,
    input  logic                              ack,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   data0,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   data1,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   data2,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   data3,
    output logic [2:0]                        count,
    output logic                              done,
    output logic                              overflow,
    output logic                              busy
);

    localparam int W  = C_S_AXIS_TDATA_WIDTH;
    localparam int NB = W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   words [4];
    logic [W-1:0]   masked;
    logic           beat;

    assign beat = S_AXIS_TVALID && S_AXIS_TREADY;

    // Bytes not qualified by TSTRB are stored as zero.
    always_comb begin
        // NOTE: assign every always_comb output first so no path leaves it unassigned (no latch).
        masked = S_AXIS_TDATA;
        for (int b = 0; b < NB; b++) begin
            if (!S_AXIS_TSTRB[b]) begin
                masked[b*8 +: 8] = 8'h00;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm) state_next = RECEIVE;
            RECEIVE: if (beat && S_AXIS_TLAST) state_next = DONE;
            DONE:    if (ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (S_AXIS_ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            // NOTE: the holding words are architecturally visible at reset, so they are reset explicitly.
            for (int i = 0; i < 4; i++) begin
                words[i] <= '0;
            end
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        for (int i = 0; i < 4; i++) begin
                            words[i] <= '0;
                        end
                        count    <= 3'd0;
                        overflow <= 1'b0;
                    end
                end
                RECEIVE: begin
                    if (beat) begin
                        if (count < 3'd4) begin
                            words[count[1:0]] <= masked;
                            count             <= count + 3'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode the state register only; no combinational path from the stream.
    assign S_AXIS_TREADY = (state == RECEIVE);
    assign busy          = (state == RECEIVE);
    assign done          = (state == DONE);

    assign data0 = words[0];
    assign data1 = words[1];
    assign data2 = words[2];
    assign data3 = words[3];

endmodule

// File: tb/tb_stream2lite_rx_interface.sv
// Self-checking bench: directed scenarios plus random packets, compared every
// cycle against a queue-level behavioural model of the capture block.
module tb_stream2lite_rx_interface;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tvalid = 1'b0;
    logic [W-1:0] tdata = '0;
    logic [3:0]   tstrb = '0;
    logic         tlast = 1'b0;
    logic         tready;
    logic         arm = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] data0, data1, data2, data3;
    logic [2:0]   count;
    logic         done, overflow, busy;

    int errors = 0;
    int checks = 0;

    stream2lite_rx_interface #(.C_S_AXIS_TDATA_WIDTH(W)) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .arm           (arm),
        .ack           (ack),
        .data0         (data0),
        .data1         (data1),
        .data2         (data2),
        .data3         (data3),
        .count         (count),
        .done          (done),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a capture is either in progress, held, or neither;
    // captured words and the packet length are tracked directly.
    bit          m_capturing = 1'b0;
    bit          m_held = 1'b0;
    bit          m_ovf = 1'b0;
    int          m_len = 0;
    logic [31:0] m_w [4] = '{default: '0};

    function automatic logic [31:0] apply_strb(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_capturing <= 1'b0;
            m_held      <= 1'b0;
            m_ovf       <= 1'b0;
            m_len       <= 0;
            for (int i = 0; i < 4; i++) m_w[i] <= '0;
        end else if (m_held) begin
            if (ack) m_held <= 1'b0;
        end else if (m_capturing) begin
            if (tvalid) begin
                if (m_len < 4) begin
                    m_w[m_len] <= apply_strb(tdata, tstrb);
                    m_len      <= m_len + 1;
                end else begin
                    m_ovf <= 1'b1;
                end
                if (tlast) begin
                    m_capturing <= 1'b0;
                    m_held      <= 1'b1;
                end
            end
        end else if (arm) begin
            m_capturing <= 1'b1;
            m_ovf       <= 1'b0;
            m_len       <= 0;
            for (int i = 0; i < 4; i++) m_w[i] <= '0;
        end
    end

    always @(posedge clk) begin
        #1;
        check("tready",   {31'd0, tready},   {31'd0, m_capturing});
        check("busy",     {31'd0, busy},     {31'd0, m_capturing});
        check("done",     {31'd0, done},     {31'd0, m_held});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("count",    {29'd0, count},    m_len);
        check("data0",    data0,             m_w[0]);
        check("data1",    data1,             m_w[1]);
        check("data2",    data2,             m_w[2]);
        check("data3",    data3,             m_w[3]);
    end

    task automatic pulse(input bit do_arm, input bit do_ack);
        arm = do_arm;
        ack = do_ack;
        @(negedge clk);
        arm = 1'b0;
        ack = 1'b0;
    endtask

    // Presents one beat after `gap` idle cycles and holds it until accepted.
    task automatic send(input logic [31:0] d, input logic [3:0] s, input bit l,
                        input int gap, input bit noise);
        int  n;
        bit  ok;
        for (int g = 0; g < gap; g++) begin
            tvalid = 1'b0;
            arm = noise && ($urandom_range(3) == 0);
            ack = noise && ($urandom_range(3) == 0);
            tdata = $urandom;
            @(negedge clk);
            arm = 1'b0;
            ack = 1'b0;
        end
        tvalid = 1'b1;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        n = 0;
        forever begin
            ok = tready;
            @(negedge clk);
            if (ok) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: tready stayed %b, required 1", tready);
                break;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    initial begin
        int len;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tready", {31'd0, tready}, 32'd0);
        check("rst_count",  {29'd0, count},  32'd0);
        check("rst_done",   {31'd0, done},   32'd0);

        // Four full beats, back to back.
        pulse(1'b1, 1'b0);
        send(32'h11111111, 4'hF, 1'b0, 0, 1'b0);
        send(32'h22222222, 4'hF, 1'b0, 0, 1'b0);
        send(32'h33333333, 4'hF, 1'b0, 0, 1'b0);
        send(32'h44444444, 4'hF, 1'b1, 0, 1'b0);
        check("t1_done",  {31'd0, done},     32'd1);
        check("t1_data0", data0,             32'h11111111);
        check("t1_data3", data3,             32'h44444444);
        check("t1_count", {29'd0, count},    32'd4);
        check("t1_ovf",   {31'd0, overflow}, 32'd0);
        pulse(1'b0, 1'b1);

        // Two-beat packet, then release.
        pulse(1'b1, 1'b0);
        send(32'hAAAA5555, 4'hF, 1'b0, 0, 1'b0);
        send(32'h0000BEEF, 4'hF, 1'b1, 0, 1'b0);
        check("t2_count", {29'd0, count}, 32'd2);
        check("t2_data1", data1,          32'h0000BEEF);
        check("t2_data2", data2,          32'h0);
        pulse(1'b0, 1'b1);
        check("t2_ack_done", {31'd0, done}, 32'd0);
        check("t2_ack_busy", {31'd0, busy}, 32'd0);
        check("t2_held",     data0,         32'hAAAA5555);

        // Single beat with sparse strobes.
        pulse(1'b1, 1'b0);
        send(32'hDEADBEEF, 4'b0101, 1'b1, 0, 1'b0);
        check("t3_data0", data0,          32'h00AD00EF);
        check("t3_count", {29'd0, count}, 32'd1);
        pulse(1'b0, 1'b1);

        // Overlong packet drains and flags overflow.
        pulse(1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) send(i, 4'hF, i == 6, 0, 1'b0);
        check("t4_data3", data3,             32'd4);
        check("t4_count", {29'd0, count},    32'd4);
        check("t4_ovf",   {31'd0, overflow}, 32'd1);
        check("t4_done",  {31'd0, done},     32'd1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        check("t4_rearm_ovf", {31'd0, overflow}, 32'd0);

        // Beats with random gaps; then simultaneous arm+ack while held.
        send(32'hCAFE0001, 4'hF, 1'b0, $urandom_range(4), 1'b0);
        send(32'hCAFE0002, 4'hF, 1'b0, $urandom_range(4), 1'b0);
        send(32'hCAFE0003, 4'hF, 1'b1, $urandom_range(4), 1'b0);
        check("t5_data2", data2, 32'hCAFE0003);
        pulse(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("t5_armack_tready", {31'd0, tready}, 32'd0);
        check("t5_armack_done",   {31'd0, done},   32'd0);

        // Reset in the middle of a packet.
        pulse(1'b1, 1'b0);
        send(32'h0BAD0001, 4'hF, 1'b0, 0, 1'b0);
        send(32'h0BAD0002, 4'hF, 1'b0, 0, 1'b0);
        tvalid = 1'b1;
        tdata  = 32'h0BAD0003;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_count",  {29'd0, count}, 32'd0);
        check("t6_data0",  data0,          32'h0);
        check("t6_tready", {31'd0, tready}, 32'd0);
        repeat (3) @(negedge clk);
        check("t6_drain_tready", {31'd0, tready}, 32'd0);
        tvalid = 1'b0;

        // Random packets with noise on arm/ack during gaps.
        for (int p = 0; p < 40; p++) begin
            pulse(1'b1, 1'b0);
            len = $urandom_range(6, 1);
            for (int b = 0; b < len; b++) begin
                send($urandom, 4'($urandom), b == len - 1, $urandom_range(3), 1'b1);
            end
            repeat ($urandom_range(3)) @(negedge clk);
            pulse($urandom_range(1) == 1, 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream2lite_rx_interface.md
Name: stream2lite_rx_interface

Overview:
- AXI-Stream slave that captures one packet of up to 4 words into holding registers.
- The registers are read by the AXI-Lite register file, so this block is the receive counterpart of the lite-to-stream transmit path.
- The lite side arms a capture, the block accepts beats until TLAST, then holds the words with a done flag until the lite side acknowledges.
- The block detects overlong packets and flags them.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, stream data width in bits; must be a multiple of 8.

Ports:
- S_AXIS_ACLK  input  1  single clock for all logic.
- S_AXIS_ARESET  input  1  synchronous reset, active-high.
- S_AXIS_TVALID  input  1  stream beat valid.
- S_AXIS_TDATA  input  C_S_AXIS_TDATA_WIDTH  stream data.
- S_AXIS_TSTRB  input  C_S_AXIS_TDATA_WIDTH/8  byte qualifiers.
- S_AXIS_TLAST  input  1  last beat of packet.
- S_AXIS_TREADY  output  1  block accepts beat.
- arm  input  1  one-cycle pulse from lite side that starts a capture.
- ack  input  1  one-cycle pulse from lite side that releases captured data.
- data0, data1, data2, data3  output  C_S_AXIS_TDATA_WIDTH each  captured words, beat 0..3.
- count  output  3  number of words stored, 0..4.
- done  output  1  packet captured and held.
- overflow  output  1  packet had more than 4 beats.
- busy  output  1  capture in progress.

Behaviour:
- Clock and reset: one clock, S_AXIS_ACLK. Reset is synchronous and active-high on S_AXIS_ARESET. All registers update on the rising edge.
- Reset values: state IDLE, S_AXIS_TREADY=0, data0..3=0, count=0, done=0, overflow=0, busy=0.
- Reset mid-packet aborts the capture; remaining beats are not accepted until a new arm.
- States: IDLE, RECEIVE, DONE. Outputs are decoded from the state register only, with no combinational path from stream inputs:
  - S_AXIS_TREADY = (state==RECEIVE)
  - busy = (state==RECEIVE)
  - done = (state==DONE)
- IDLE:
  - On arm=1: clear data0..3, count and overflow to 0, then go to RECEIVE. TREADY rises the cycle after arm.
  - ack is ignored in IDLE.
- RECEIVE, beat accepted when TVALID&&TREADY:
  - If count<4: write data[count] <= TDATA, with each byte whose TSTRB bit is 0 stored as 0x00; then count <= count+1.
  - If count==4: discard the data, set overflow=1 (sticky until next arm), and leave count at 4. The block keeps accepting beats to drain the packet.
  - If TLAST is set on the accepted beat: go to DONE. TREADY falls and done rises on the next cycle (1-cycle latency from the TLAST beat to done).
  - TVALID low cycles are ignored, with no timeout.
  - arm and ack are ignored in RECEIVE.
- DONE:
  - TREADY=0; data0..3, count and overflow are held stable for register reads.
  - On ack=1: go to IDLE; data0..3 and count stay held until the next arm.
  - arm alone in DONE is ignored. When arm and ack arrive in the same cycle, ack wins: go to IDLE and drop the arm.
- Width rules:
  - count is 3 bits and saturates at 4.
  - The write index is count[1:0], valid only while count<4.
- A single-beat packet with TLAST on the first beat gives count=1 and writes data0 only.

Test Plan:
- Reset, arm, 4 beats 0x11111111..0x44444444 with TLAST on beat 4, TSTRB=0xF -> TREADY high for 4 cycles; done=1 one cycle after beat 4; data0..3 match; count=4; overflow=0.
- Arm, 2 beats 0xAAAA5555 and 0x0000BEEF with TLAST on beat 2 -> count=2, data0=0xAAAA5555, data1=0x0000BEEF, data2=data3=0. Then ack -> done=0, busy=0; data is still held.
- Arm, 1 beat 0xDEADBEEF with TSTRB=4'b0101 and TLAST -> data0=0x00AD00EF, count=1.
- Arm, 6 beats 1..6 with TLAST on beat 6 -> all 6 beats accepted, data0..3=1..4, count=4, overflow=1, done=1. A subsequent arm clears overflow.
- Arm, beats separated by random TVALID gaps -> only TVALID&&TREADY cycles are captured. While done=1, an arm+ack pulse in the same cycle -> IDLE with TREADY still 0; the arm is dropped.
- Arm, 2 of 4 beats sent, then S_AXIS_ARESET for one cycle -> all outputs are 0 next cycle, and the remaining beats see TREADY=0.
